// File: rtl/cp0_exc_pkg.sv
// cp0_exc_pkg: CP0 register numbers, exception codes and SR/Cause field positions
package cp0_exc_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_SR = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] CP0_PRID = 5'd15;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam int SR_IE = 0;
  localparam int SR_EXL = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_BD = 31;
endpackage

// File: rtl/cp0_exc_if.sv
// cp0_exc_if: pipeline-side signals of the CP0 exception unit; BadVAddrIn exists only with CP0_BADVADDR_EN
interface cp0_exc_if;
  logic [31:0] PC;
  logic BD;
  logic [4:0] ExcCodeIn;
  logic [5:0] HWInt;
  logic [4:0] A1;
  logic [4:0] A2;
  logic [31:0] DIn;
  logic We;
  logic EXLClr;
`ifdef CP0_BADVADDR_EN
  logic [31:0] BadVAddrIn;
`endif
  logic Exception;
  logic [31:0] HandlerPC;
  logic [31:0] EPCOut;
  logic [31:0] DOut;
  modport master(
    output PC, BD, ExcCodeIn, HWInt, A1, A2, DIn, We, EXLClr,
`ifdef CP0_BADVADDR_EN
    output BadVAddrIn,
`endif
    input Exception, HandlerPC, EPCOut, DOut
  );
  modport slave(
    input PC, BD, ExcCodeIn, HWInt, A1, A2, DIn, We, EXLClr,
`ifdef CP0_BADVADDR_EN
    input BadVAddrIn,
`endif
    output Exception, HandlerPC, EPCOut, DOut
  );
endinterface

// File: rtl/cp0_exc_req.sv
// cp0_req: combinational interrupt/exception request evaluation, interrupts win over exceptions
module cp0_req
  import cp0_exc_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       exception,
  output logic [4:0] exc_code
);
  logic int_req;
  logic exc_req;
  always_comb begin
    int_req = |(hw_int & im) & ie & ~exl;
    exc_req = (exc_code_in != EXC_INT) & ~exl;
    exception = int_req | exc_req;
    exc_code = int_req ? EXC_INT : exc_code_in;
  end
endmodule

// File: rtl/cp0_exc.sv
// cp0_exc: CP0 SR/Cause/EPC/PRId state, exception capture, mfc0/mtc0/eret; CP0_BADVADDR_EN adds BadVAddr (reg 8)
module cp0_exc
  import cp0_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE = 32'h4252_4348
) (
  input logic clk,
  input logic reset,
  cp0_exc_if.slave bus
);
  logic [5:0] im;
  logic exl;
  logic ie;
  logic bd;
  logic [5:0] ip;
  logic [4:0] exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic exc;
  logic [4:0] code;
  logic we_sr;
  logic we_epc;
  cp0_req u_req (
    .hw_int(bus.HWInt),
    .im(im),
    .ie(ie),
    .exl(exl),
    .exc_code_in(bus.ExcCodeIn),
    .exception(exc),
    .exc_code(code)
  );
  assign we_sr = bus.We && bus.A2 == CP0_SR;
  assign we_epc = bus.We && bus.A2 == CP0_EPC;
  // exception capture beats mtc0/eret for EXL and EPC; IM/IE always follow mtc0
  always_ff @(posedge clk) begin
    if (reset) begin
      im <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      ip <= '0;
      exc_code <= '0;
      epc <= '0;
    end else begin
      ip <= bus.HWInt;
      im <= we_sr ? bus.DIn[SR_IM_HI:SR_IM_LO] : im;
      ie <= we_sr ? bus.DIn[SR_IE] : ie;
      exl <= exc ? 1'b1 : bus.EXLClr ? 1'b0 : we_sr ? bus.DIn[SR_EXL] : exl;
      bd <= exc ? bus.BD : bd;
      exc_code <= exc ? code : exc_code;
      epc <= exc ? (bus.BD ? bus.PC - 32'd4 : bus.PC) & ~32'd3 : we_epc ? {bus.DIn[31:2], 2'b00} : epc;
    end
  end
`ifdef CP0_BADVADDR_EN
  // a nonzero selected code of AdEL/AdES already implies no interrupt won
  always_ff @(posedge clk) begin
    if (reset) badvaddr <= '0;
    else if (exc && (code == EXC_ADEL || code == EXC_ADES)) badvaddr <= bus.BadVAddrIn;
  end
`else
  assign badvaddr = '0;
`endif
  always_comb begin
    sr_val = '0;
    sr_val[SR_IM_HI:SR_IM_LO] = im;
    sr_val[SR_EXL] = exl;
    sr_val[SR_IE] = ie;
    cause_val = '0;
    cause_val[CAUSE_BD] = bd;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
    bus.DOut = bus.A1 == CP0_SR ? sr_val :
               bus.A1 == CP0_CAUSE ? cause_val :
               bus.A1 == CP0_EPC ? epc :
               bus.A1 == CP0_PRID ? PRID_VALUE :
               bus.A1 == CP0_BADVADDR ? badvaddr : 32'd0;
  end
  assign bus.Exception = exc;
  assign bus.HandlerPC = HANDLER_ADDR;
  assign bus.EPCOut = epc;
endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed self-checking bench for cp0_exc; BadVAddr steps run when CP0_BADVADDR_EN is defined
module tb_cp0_exc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  cp0_exc_if bus();
  cp0_exc dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.A1 = a;
    #1;
    chk(tag, bus.DOut, exp);
  endtask
  initial begin
    bus.PC = '0; bus.BD = 0; bus.ExcCodeIn = '0; bus.HWInt = '0; bus.A1 = '0; bus.A2 = '0;
    bus.DIn = '0; bus.We = 0; bus.EXLClr = 0;
`ifdef CP0_BADVADDR_EN
    bus.BadVAddrIn = '0;
`endif
    edge_step();
    reset = 0;
    chk("reset_exc", {31'd0, bus.Exception}, 32'd0);
    rd("reset_sr", 5'd12, 32'd0);
    rd("reset_cause", 5'd13, 32'd0);
    rd("reset_epc", 5'd14, 32'd0);
    rd("prid", 5'd15, 32'h4252_4348);
    chk("handler_pc", bus.HandlerPC, 32'h0000_4180);
    rd("unlisted_reg", 5'd3, 32'd0);
    // interrupt entry
    bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    edge_step();
    bus.We = 0; bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 0;
    #1;
    chk("int_exc", {31'd0, bus.Exception}, 32'd1);
    edge_step();
    chk("int_exc_drop", {31'd0, bus.Exception}, 32'd0);
    chk("int_epcout", bus.EPCOut, 32'h0000_3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    // eret then delay-slot overflow
    bus.HWInt = '0; bus.EXLClr = 1;
    edge_step();
    bus.EXLClr = 0; bus.ExcCodeIn = 5'd12; bus.BD = 1; bus.PC = 32'h0000_3020;
    #1;
    chk("ov_exc", {31'd0, bus.Exception}, 32'd1);
    edge_step();
    bus.ExcCodeIn = '0; bus.BD = 0;
    rd("ov_epc", 5'd14, 32'h0000_301C);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    // masking by EXL
    bus.ExcCodeIn = 5'd10;
    #1;
    chk("exl_mask", {31'd0, bus.Exception}, 32'd0);
    edge_step();
    rd("exl_mask_cause", 5'd13, 32'h8000_0030);
    bus.ExcCodeIn = '0; bus.EXLClr = 1;
    edge_step();
    // eret coinciding with an exception
    bus.ExcCodeIn = 5'd10; bus.PC = 32'h0000_3040;
    #1;
    chk("clr_exc", {31'd0, bus.Exception}, 32'd1);
    edge_step();
    bus.ExcCodeIn = '0;
    rd("clr_sr", 5'd12, 32'h0000_0403);
    rd("clr_cause", 5'd13, 32'h0000_0028);
    edge_step();
    // interrupt beats AdEL
    bus.EXLClr = 0; bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd4; bus.PC = 32'h0000_3050;
    #1;
    chk("prio_exc", {31'd0, bus.Exception}, 32'd1);
    edge_step();
    bus.ExcCodeIn = '0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    rd("prio_epc", 5'd14, 32'h0000_3050);
    // mtc0 rules
    bus.HWInt = '0; bus.We = 1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
    edge_step();
    chk("mtc0_epc", bus.EPCOut, 32'h0000_3004);
    bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    edge_step();
    rd("mtc0_cause", 5'd13, 32'h0000_0000);
    bus.We = 0; bus.EXLClr = 1;
    edge_step();
    bus.EXLClr = 0; bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000;
    bus.ExcCodeIn = 5'd12; bus.PC = 32'h0000_3060;
    #1;
    chk("mtc0_exc", {31'd0, bus.Exception}, 32'd1);
    edge_step();
    bus.ExcCodeIn = '0;
    rd("mtc0_sr_exc", 5'd12, 32'h0000_0002);
    rd("mtc0_sr_epc", 5'd14, 32'h0000_3060);
    // mtc0 SR with eret: eret clears EXL, IM/IE follow DIn
    bus.EXLClr = 1; bus.DIn = 32'h0000_0403;
    edge_step();
    bus.EXLClr = 0; bus.We = 0;
    rd("mtc0_sr_clr", 5'd12, 32'h0000_0401);
    chk("idle_exc", {31'd0, bus.Exception}, 32'd0);
    // pending interrupt re-asserts after eret
    bus.HWInt = 6'b000001;
    edge_step();
    bus.EXLClr = 1;
    #1;
    chk("pend_masked", {31'd0, bus.Exception}, 32'd0);
    edge_step();
    bus.EXLClr = 0;
    chk("pend_reassert", {31'd0, bus.Exception}, 32'd1);
    // reset overrides a coincident exception
    reset = 1; bus.ExcCodeIn = 5'd12;
    edge_step();
    reset = 0; bus.ExcCodeIn = '0; bus.HWInt = '0;
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
`ifdef CP0_BADVADDR_EN
    bus.BadVAddrIn = 32'h0000_0001; bus.ExcCodeIn = 5'd4; bus.PC = 32'h0000_3070;
    edge_step();
    bus.ExcCodeIn = '0; bus.EXLClr = 1;
    rd("badv_adel", 5'd8, 32'h0000_0001);
    edge_step();
    bus.EXLClr = 0; bus.BadVAddrIn = 32'h0000_0055; bus.ExcCodeIn = 5'd12;
    edge_step();
    bus.ExcCodeIn = '0;
    rd("badv_ov", 5'd8, 32'h0000_0001);
`else
    rd("badv_absent", 5'd8, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
